// File: rtl/digit_collector_if.sv
// Keypad-side and consumer-side signals of the digit collector, grouped so
// the collector and whatever drives it see one bundle.
//   master : the environment (keypad encoder + code consumer)
//   slave  : the digit collector itself
interface digit_collector_if #(
  parameter int NUM_DIGITS = 4
);
  logic [3:0]              bcd;
  logic                    valid_data;
  logic                    clear;
  logic                    ack;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [3:0]              digit_count;
  logic                    code_ready;
  logic                    timeout;
  logic                    encoder_enablen;

  modport master (
    output bcd, valid_data, clear, ack,
    input  digits, digit_count, code_ready, timeout, encoder_enablen
  );

  modport slave (
    input  bcd, valid_data, clear, ack,
    output digits, digit_count, code_ready, timeout, encoder_enablen
  );
endinterface

// File: rtl/digit_collector.sv
// Collects NUM_DIGITS BCD keypad digits into one code. Key presses arrive
// asynchronously and are synchronised and edge-detected, so one press gives
// one digit. A partial entry that sits idle for TIMEOUT_CYCLES clocks is
// discarded. A complete code is held, with the keypad disabled, until the
// consumer acknowledges it.
module digit_collector #(
  parameter int NUM_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             resetn,
  digit_collector_if.slave bus
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    FULL      = 4'(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    READY
  } state_t;

  // Synchroniser and edge-detect stages
  logic       valid_s1, valid_s2, valid_s3;
  logic [3:0] bcd_s1, bcd_s2;
  // Fills with ones after reset. The edge detector is trusted only once
  // valid_s3 holds a genuine sample, so a key already held when reset is
  // released does not count as a press.
  logic [2:0] sync_live;
  logic       key_edge;
  logic       digit_ok;

  // Collection state
  state_t         state, state_next;
  logic [DW-1:0]  digits_q, digits_next;
  logic [3:0]     count_q, count_next;
  logic [IW-1:0]  idle_q, idle_next;
  logic           timeout_q, timeout_next;

  // Bring the keypad signals into the clk domain and keep one older valid
  // sample for rising-edge detection.
  // NOTE: sequential state uses non-blocking (<=) assignments so every flop
  // samples its pre-edge input; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_s1  <= 1'b0;
      valid_s2  <= 1'b0;
      valid_s3  <= 1'b0;
      bcd_s1    <= 4'd0;
      bcd_s2    <= 4'd0;
      sync_live <= 3'b000;
    end else begin
      valid_s1  <= bus.valid_data;
      valid_s2  <= valid_s1;
      valid_s3  <= valid_s2;
      bcd_s1    <= bus.bcd;
      bcd_s2    <= bcd_s1;
      sync_live <= {sync_live[1:0], 1'b1};
    end
  end

  assign key_edge = sync_live[2] & valid_s2 & ~valid_s3;
  assign digit_ok = key_edge & (bcd_s2 <= 4'd9);

  // State, code, count, idle counter and timeout pulse registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      digits_q  <= '0;
      count_q   <= 4'd0;
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      digits_q  <= digits_next;
      count_q   <= count_next;
      idle_q    <= idle_next;
      timeout_q <= timeout_next;
    end
  end

  // Next-state logic; priority is clear > ack > timeout > digit accept.
  // NOTE: every variable gets a default before any branch, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    digits_next  = digits_q;
    count_next   = count_q;
    idle_next    = idle_q;
    timeout_next = 1'b0;

    if (bus.clear) begin
      state_next  = IDLE;
      digits_next = '0;
      count_next  = 4'd0;
      idle_next   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (digit_ok) begin
            digits_next = DW'(bcd_s2);
            count_next  = 4'd1;
            idle_next   = '0;
            state_next  = (NUM_DIGITS == 1) ? READY : COLLECT;
          end
        end

        COLLECT: begin
          if (idle_q == IDLE_LAST) begin
            // Expiry beats a digit arriving on the same edge.
            state_next   = IDLE;
            digits_next  = '0;
            count_next   = 4'd0;
            idle_next    = '0;
            timeout_next = 1'b1;
          end else if (digit_ok) begin
            digits_next = (digits_q << 4) | DW'(bcd_s2);
            count_next  = count_q + 4'd1;
            idle_next   = '0;
            if (count_next == FULL) begin
              state_next = READY;
            end
          end else begin
            idle_next = idle_q + 1'b1;
          end
        end

        READY: begin
          // Code is frozen; key edges are ignored until acknowledged.
          if (bus.ack) begin
            state_next  = IDLE;
            digits_next = '0;
            count_next  = 4'd0;
            idle_next   = '0;
          end
        end

        default: begin
          state_next  = IDLE;
          digits_next = '0;
          count_next  = 4'd0;
          idle_next   = '0;
        end
      endcase
    end
  end

  assign bus.digits          = digits_q;
  assign bus.digit_count     = count_q;
  assign bus.code_ready      = (state == READY);
  assign bus.encoder_enablen = (state == READY);
  assign bus.timeout         = timeout_q;

endmodule
